dmem_responder: RTL and testbench

Memory-side responder for the core's data-memory port (addr, write_data, mask, rd_en, wr_en, cs). It accepts one load or store at a time, holds it for a programmable number of wait cycles, and commits or returns the word with per-byte-lane masking. It then pulses `ready` to complete the access. It replaces the zero-latency data memory wherever the core is run against slow or wait-stated storage.

---
 rtl/dmem_pkg.sv | 18 +
 rtl/dmem_bank.sv | 35 +++
 rtl/dmem_responder.sv | 133 +++++++++++++
 tb/tb_dmem_responder.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: FSM state type, default geometry and byte-lane helper for dmem_responder.
// No logic of its own; range checking in the responder is enabled with DMEM_ERR_EN.
package dmem_pkg;

  localparam int unsigned DMEM_DEPTH_WORDS = 1024;
  localparam int unsigned DMEM_IDX_W       = $clog2(DMEM_DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  function automatic logic [31:0] lane_expand(input logic [3:0] mask);
    return {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// dmem_bank: word array with byte-lane write enables and a registered read port.
// One access per enabled edge, write or read; no backpressure. Contents are never reset.
module dmem_bank
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DMEM_DEPTH_WORDS,
  parameter int unsigned IDX_W       = DMEM_IDX_W
) (
  input  logic             clk,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [3:0]       be_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;
  logic [31:0] bmask;

  assign bmask = lane_expand(be_i);

  always_ff @(posedge clk) begin
    if (en_i && we_i) begin
      mem_q[idx_i] <= (mem_q[idx_i] & ~bmask) | (wdata_i & bmask);
    end
    if (en_i && !we_i) begin
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated data-memory responder; ready pulses WAIT_CYCLES+1 edges after capture.
// Requests are only accepted in IDLE (initiator holds until ready). Define DMEM_ERR_EN for range errors.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DMEM_DEPTH_WORDS,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic [3:0]  mask,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  dmem_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, wdata_q;
  logic [3:0]       mask_q;
  logic             wr_q;
  logic             capture, commit;
  logic [31:0]      cur_addr, cur_wdata, offset;
  logic [3:0]       cur_mask;
  logic             cur_wr, cur_err, err_q;
  logic [IDX_W-1:0] idx;
  logic [31:0]      bank_rdata;
  logic             unused_offset;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs && (rd_en || wr_en)) begin
          capture = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With zero wait states the commit shares the capture edge, so the live inputs feed the bank.
  assign cur_addr  = (state_q == IDLE) ? addr       : addr_q;
  assign cur_wdata = (state_q == IDLE) ? write_data : wdata_q;
  assign cur_mask  = (state_q == IDLE) ? mask       : mask_q;
  assign cur_wr    = (state_q == IDLE) ? wr_en      : wr_q;

  assign offset        = cur_addr - BASE_ADDR;
  assign idx           = offset[IDX_W+1:2];
  assign unused_offset = ^offset;

`ifdef DMEM_ERR_EN
  assign cur_err = (cur_addr < BASE_ADDR) || ({2'b00, offset[31:2]} >= 32'(DEPTH_WORDS));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (commit) begin
      err_q <= cur_err;
    end
  end
`else
  assign cur_err = 1'b0;
  assign err_q   = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        addr_q  <= addr;
        wdata_q <= write_data;
        mask_q  <= mask;
        wr_q    <= wr_en;
      end
    end
  end

  dmem_bank #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_bank (
    .clk    (clk),
    .en_i   (commit && !cur_err),
    .we_i   (cur_wr),
    .be_i   (cur_mask),
    .idx_i  (idx),
    .wdata_i(cur_wdata),
    .rdata_o(bank_rdata)
  );

  assign ready     = (state_q == RESP);
  assign read_data = (ready && !wr_q && !err_q) ? (bank_rdata & lane_expand(mask_q)) : '0;
  assign err       = ready && err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a 1-wait-state and a 0-wait-state instance against a byte-array model.
// Define DMEM_ERR_EN for both RTL and bench to exercise the range-error build.
module tb_dmem_responder;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int unsigned DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs      [2];
  logic        rd_en   [2];
  logic        wr_en   [2];
  logic [31:0] addr    [2];
  logic [31:0] wdata   [2];
  logic [3:0]  mask    [2];
  logic [31:0] rdata   [2];
  logic        ready   [2];
  logic        err     [2];

  int n_vec = 0;
  int n_err = 0;

  bit [7:0] ref_mem [2][DEPTH][4];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1), .BASE_ADDR(BASE)) dut_w1 (
    .clk(clk), .reset(reset), .cs(cs[0]), .rd_en(rd_en[0]), .wr_en(wr_en[0]),
    .addr(addr[0]), .write_data(wdata[0]), .mask(mask[0]),
    .read_data(rdata[0]), .ready(ready[0]), .err(err[0])
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .BASE_ADDR(BASE)) dut_w0 (
    .clk(clk), .reset(reset), .cs(cs[1]), .rd_en(rd_en[1]), .wr_en(wr_en[1]),
    .addr(addr[1]), .write_data(wdata[1]), .mask(mask[1]),
    .read_data(rdata[1]), .ready(ready[1]), .err(err[1])
  );

  function automatic int wait_of(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference behaviour: byte-addressed word store, write wins over read, masked lanes only.
  task automatic model(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] m, output logic [31:0] exp_rd, output bit exp_err);
    logic [31:0] off;
    int unsigned idx_full;
    int unsigned idx;
    off      = a - BASE;
    idx_full = off / 4;
    idx      = idx_full % DEPTH;
    exp_err  = 1'b0;
`ifdef DMEM_ERR_EN
    exp_err  = (a < BASE) || (idx_full >= DEPTH);
`endif
    exp_rd = '0;
    if (!exp_err) begin
      for (int i = 0; i < 4; i++) begin
        if (m[i]) begin
          if (wr) ref_mem[d][idx][i] = wd[8*i +: 8];
          else    exp_rd[8*i +: 8] = ref_mem[d][idx][i];
        end
      end
    end
  endtask

  task automatic run(input int d, input bit rd, input bit wr, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] m, input string tag);
    logic [31:0] exp_rd;
    bit          exp_err;
    int          lat;
    bit          seen;
    model(d, wr, a, wd, m, exp_rd, exp_err);
    cs[d] = 1'b1; rd_en[d] = rd; wr_en[d] = wr;
    addr[d] = a; wdata[d] = wd; mask[d] = m;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (ready[d]) seen = 1'b1;
    end
    cs[d] = 1'b0; rd_en[d] = 1'b0; wr_en[d] = 1'b0;
    check({tag, "_latency"}, lat, wait_of(d) + 1);
    check({tag, "_rdata"}, rdata[d], exp_rd);
    check({tag, "_err"}, {31'b0, err[d]}, {31'b0, exp_err});
    @(posedge clk); #1;
    check({tag, "_pulse"}, {31'b0, ready[d]}, 32'd0);
    check({tag, "_rdata_idle"}, rdata[d], 32'd0);
  endtask

  initial begin
    logic [31:0] a, wd, exp_rd;
    bit          exp_err;
    int          done;
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      cs[d] = 1'b0; rd_en[d] = 1'b0; wr_en[d] = 1'b0;
      addr[d] = '0; wdata[d] = '0; mask[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("reset_ready", {31'b0, ready[d]}, 32'd0);
      check("reset_rdata", rdata[d], 32'd0);
      check("reset_err", {31'b0, err[d]}, 32'd0);
    end
    reset = 1'b1;
    @(posedge clk); #1;

    for (int w = 0; w < 16; w++) begin
      for (int d = 0; d < 2; d++) run(d, 1'b0, 1'b1, w * 4, $urandom, 4'hF, "init");
    end

    run(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "st_full");
    run(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, "ld_full");
    run(0, 1'b0, 1'b1, 32'h10, 32'h0000AA00, 4'b0010, "st_byte");
    run(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, "ld_after_byte");
    run(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'b1100, "ld_upper");
    run(0, 1'b1, 1'b1, 32'h20, 32'h12345678, 4'hF, "rd_wr_both");
    run(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF, "ld_both");
    run(0, 1'b0, 1'b1, 32'h24, 32'hFFFFFFFF, 4'h0, "st_mask0");
    run(0, 1'b1, 1'b0, 32'h24, 32'h0, 4'h0, "ld_mask0");
    run(0, 1'b1, 1'b0, 32'h24, 32'h0, 4'hF, "ld_after_mask0");

    // Abort a store while it sits in WAIT.
    run(0, 1'b0, 1'b1, 32'h30, 32'h1, 4'hF, "pre_abort");
    cs[0] = 1'b1; wr_en[0] = 1'b1; addr[0] = 32'h30; wdata[0] = 32'hFFFFFFFF; mask[0] = 4'hF;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("abort_ready", {31'b0, ready[0]}, 32'd0);
    check("abort_rdata", rdata[0], 32'd0);
    check("abort_err", {31'b0, err[0]}, 32'd0);
    cs[0] = 1'b0; wr_en[0] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("abort_no_ready", {31'b0, ready[0]}, 32'd0);
    end
    run(0, 1'b1, 1'b0, 32'h30, 32'h0, 4'hF, "ld_after_abort");

    run(0, 1'b1, 1'b0, 32'h1000, 32'h0, 4'hF, "ld_0x1000");
    run(1, 1'b1, 1'b0, 32'h1004, 32'h0, 4'hF, "ld_0x1004_w0");

    for (int n = 0; n < 60; n++) begin
      for (int d = 0; d < 2; d++) begin
        int op;
        op = $urandom_range(0, 2);
        a  = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) a = a + 32'h1000 * $urandom_range(1, 3);
        run(d, op != 1, op != 0, a, $urandom, 4'($urandom_range(0, 15)), "rand");
      end
    end

    // Zero-wait instance with one load held continuously: completes every second edge.
    model(1, 1'b0, 32'h10, 32'h0, 4'hF, exp_rd, exp_err);
    cs[1] = 1'b1; rd_en[1] = 1'b1; wr_en[1] = 1'b0; addr[1] = 32'h10; mask[1] = 4'hF;
    done = 0;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      check("b2b_ready", {31'b0, ready[1]}, {31'b0, (n % 2) == 1});
      if (ready[1]) begin
        done++;
        check("b2b_rdata", rdata[1], exp_rd);
      end
    end
    cs[1] = 1'b0; rd_en[1] = 1'b0;
    check("b2b_count", done, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
